// File: rtl/apb_shadow_reg_bank.sv
// Configuration/status register bank for the APB timer: byte-strobed writes,
// double-buffered shadow registers committed by a pulse, W1C status registers.
module apb_shadow_reg_bank #(
  parameter int                 WIDTH       = 32,
  parameter int                 NUM_REG     = 8,
  parameter int                 ADDR_W      = $clog2(NUM_REG),
  parameter logic [WIDTH-1:0]   RST_VAL     = '0,
  parameter logic [NUM_REG-1:0] SHADOW_MASK = '0,
  parameter logic [NUM_REG-1:0] W1C_MASK    = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [WIDTH/8-1:0]            wr_strb,
  input  logic                          commit,
  input  logic [NUM_REG-1:0][WIDTH-1:0] hw_set,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [WIDTH-1:0]              rd_data,
  output logic [NUM_REG-1:0][WIDTH-1:0] q,
  output logic [NUM_REG-1:0]            pending,
  output logic                          err
);
  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]   w_byte_mask;
  logic [NUM_REG-1:0] w_wr_hit;
  logic [NUM_REG-1:0] w_rd_hit;
  logic               w_wr_act;
  logic               w_wr_oob;
  logic               w_rd_oob;
  logic [WIDTH-1:0]   w_rd_val;
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_err;
  logic               w_unused_inputs;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_byte_mask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_byte_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  // Index decode doubles as the range check: no hit means the index is out of range.
  always_comb begin
    w_wr_hit = '0;
    w_rd_hit = '0;
    w_rd_val = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      w_wr_hit[i] = (wr_addr == ADDR_W'(i));
      w_rd_hit[i] = (rd_addr == ADDR_W'(i));
      if (w_rd_hit[i]) begin
        w_rd_val = q[i];
      end
    end
  end

  // A write with no byte enabled is a no-op everywhere, including the error flag.
  assign w_wr_act = wr_en && (|wr_strb);
  assign w_wr_oob = w_wr_act && !(|w_wr_hit);
  assign w_rd_oob = rd_en && !(|w_rd_hit);

  // hw_set and commit are only consumed by W1C / shadow registers, which may not exist.
  assign w_unused_inputs = ^{hw_set, commit};

  for (genvar g = 0; g < NUM_REG; g++) begin : g_reg
    logic w_we;
    assign w_we = w_wr_act && w_wr_hit[g];

    if (W1C_MASK[g]) begin : g_w1c
      logic [WIDTH-1:0] r_active;
      logic [WIDTH-1:0] w_clr;
      assign w_clr = w_we ? (wr_data & w_byte_mask) : '0;
      // Clear first, then OR in hardware sets so a simultaneous set wins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_active <= RST_VAL;
        end else begin
          r_active <= (r_active & ~w_clr) | hw_set[g];
        end
      end
      assign q[g]       = r_active;
      assign pending[g] = 1'b0;
    end else if (SHADOW_MASK[g]) begin : g_shadow
      logic [WIDTH-1:0] r_active;
      logic [WIDTH-1:0] r_shadow;
      logic             r_pend;
      // Commit copies the shadow value held before this cycle's write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_active <= RST_VAL;
          r_shadow <= RST_VAL;
          r_pend   <= 1'b0;
        end else begin
          if (commit && r_pend) begin
            r_active <= r_shadow;
          end
          if (w_we) begin
            r_shadow <= (r_shadow & ~w_byte_mask) | (wr_data & w_byte_mask);
            r_pend   <= 1'b1;
          end else if (commit) begin
            r_pend   <= 1'b0;
          end
        end
      end
      assign q[g]       = r_active;
      assign pending[g] = r_pend;
    end else begin : g_plain
      logic [WIDTH-1:0] r_active;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_active <= RST_VAL;
        end else if (w_we) begin
          r_active <= (r_active & ~w_byte_mask) | (wr_data & w_byte_mask);
        end
      end
      assign q[g]       = r_active;
      assign pending[g] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_wr_oob || w_rd_oob;
      if (rd_en) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  assign rd_data = r_rd_data;
  assign err     = r_err;

endmodule

// File: tb/tb_apb_shadow_reg_bank.sv
// Self-checking bench for apb_shadow_reg_bank: directed cases plus random
// traffic compared against an array-based reference model.
module tb_apb_shadow_reg_bank;
  localparam int         NR   = 6;
  localparam int         W    = 32;
  localparam int         AW   = 3;
  localparam logic [5:0] SHM  = 6'b110010;  // reg 5 is also W1C, which must win
  localparam logic [5:0] W1CM = 6'b100001;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [W-1:0]        wr_data;
  logic [W/8-1:0]      wr_strb;
  logic                commit;
  logic [NR-1:0][W-1:0] hw_set;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [W-1:0]        rd_data;
  logic [NR-1:0][W-1:0] q;
  logic [NR-1:0]       pending;
  logic                err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_act [NR];
  logic [W-1:0] m_sh  [NR];
  logic         m_pend[NR];
  logic [W-1:0] m_rd;
  logic         m_err;

  apb_shadow_reg_bank #(
    .WIDTH(W), .NUM_REG(NR), .ADDR_W(AW), .RST_VAL('0),
    .SHADOW_MASK(SHM), .W1C_MASK(W1CM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .commit(commit), .hw_set(hw_set),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .q(q),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    commit = 1'b0; hw_set = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_act[i] = '0; m_sh[i] = '0; m_pend[i] = 1'b0;
    end
    m_rd = '0; m_err = 1'b0;
  endtask

  // One clock of the register-bank rules, applied to the current inputs.
  task automatic model_step();
    logic [W-1:0] bm;
    bit wr_valid;
    bit hit;
    bm = '0;
    for (int b = 0; b < W/8; b++) if (wr_strb[b]) bm[b*8 +: 8] = 8'hFF;
    wr_valid = wr_en && (wr_strb != 0);
    if (rd_en) m_rd = (int'(rd_addr) < NR) ? m_act[rd_addr] : '0;
    m_err = (wr_valid && int'(wr_addr) >= NR) || (rd_en && int'(rd_addr) >= NR);
    for (int i = 0; i < NR; i++) begin
      hit = wr_valid && (int'(wr_addr) == i);
      if (W1CM[i]) begin
        if (hit) m_act[i] = m_act[i] & ~(wr_data & bm);
        m_act[i] = m_act[i] | hw_set[i];
      end else if (SHM[i]) begin
        if (commit && m_pend[i]) m_act[i] = m_sh[i];
        if (hit) begin
          m_sh[i]   = (m_sh[i] & ~bm) | (wr_data & bm);
          m_pend[i] = 1'b1;
        end else if (commit) begin
          m_pend[i] = 1'b0;
        end
      end else if (hit) begin
        m_act[i] = (m_act[i] & ~bm) | (wr_data & bm);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NR-1:0][W-1:0] eq;
    logic [NR-1:0]        ep;
    for (int i = 0; i < NR; i++) begin
      eq[i] = m_act[i];
      ep[i] = m_pend[i];
    end
    check({tag, "_q"}, q, eq);
    check({tag, "_pending"}, pending, ep);
    check({tag, "_rd_data"}, rd_data, m_rd);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 check_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain register, partial byte strobes, then read back.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hAABBCCDD; wr_strb = 4'b0101;
    step("plain_wr");
    check("plain_q2", q[2], 32'h00BB00DD);
    idle(); rd_en = 1'b1; rd_addr = 3'd2;
    step("plain_rd");
    check("plain_rd2", rd_data, 32'h00BB00DD);

    // Shadow register: write holds, commit transfers.
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h1234; wr_strb = 4'hF;
    step("sh_wr");
    check("sh_hold_q1", q[1], 32'h0);
    check("sh_pend_set", pending[1], 1'b1);
    idle(); commit = 1'b1;
    step("sh_commit");
    check("sh_commit_q1", q[1], 32'h1234);
    check("sh_pend_clr", pending[1], 1'b0);

    // Write and commit together: old shadow moves, new data stays pending.
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h1234; wr_strb = 4'hF;
    step("sh_wr2");
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h5678; wr_strb = 4'hF; commit = 1'b1;
    step("sh_wr_commit");
    check("sh_wc_q1", q[1], 32'h1234);
    check("sh_wc_pend", pending[1], 1'b1);
    idle(); commit = 1'b1;
    step("sh_commit2");
    check("sh_commit2_q1", q[1], 32'h5678);

    // W1C: set, then clear with a simultaneous set on bit 0.
    idle(); hw_set[0] = 32'hF;
    step("w1c_set");
    check("w1c_q0_f", q[0], 32'hF);
    idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h3; wr_strb = 4'hF; hw_set[0] = 32'h1;
    step("w1c_clr");
    check("w1c_q0_d", q[0], 32'hD);

    // hw_set ignored on a plain register; reg 5 behaves as W1C despite its shadow bit.
    idle(); hw_set[2] = '1; hw_set[5] = 32'h80;
    step("hw_set_mix");
    check("hw_ign_q2", q[2], 32'h00BB00DD);
    check("w1c_ovr_q5", q[5], 32'h80);
    idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h80; wr_strb = 4'h1;
    step("w1c5_clr");
    check("w1c_ovr_clr_q5", q[5], 32'h0);
    check("w1c_ovr_pend5", pending[5], 1'b0);

    // Out-of-range accesses.
    idle(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = '1; wr_strb = 4'hF;
    step("oob_wr");
    check("oob_wr_err", err, 1'b1);
    idle();
    step("oob_idle");
    check("oob_err_pulse", err, 1'b0);
    idle(); rd_en = 1'b1; rd_addr = 3'd7;
    step("oob_rd");
    check("oob_rd_zero", rd_data, 32'h0);
    check("oob_rd_err", err, 1'b1);
    idle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = '1; wr_strb = 4'h0;
    step("oob_nostrb");
    check("oob_nostrb_err", err, 1'b0);

    // Asynchronous reset in the middle of a write.
    idle(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    commit = 1'b1; rd_en = 1'b1; rd_addr = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_reset");
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      idle();
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_strb = 4'($urandom_range(0, 15));
      commit  = ($urandom_range(0, 3) == 0);
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++) begin
        hw_set[i] = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
